mem_copy_dma: RTL and testbench

Bus-master engine that drives the single-port data memory's address/read/write interface to move blocks of bytes without processor involvement. It performs a memory-to-memory copy, or a constant fill, over up to 255 bytes, with 8-bit modulo-256 addressing. It sits beside the core and owns the memory port while `busy` is high; the top level muxes the memory port between the core and this block on `busy`.

---
 rtl/mem_copy_dma.sv | 95 +++++++++
 tb/tb_mem_copy_dma.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/mem_copy_dma.sv
// mem_copy_dma: bus-master block copy / constant fill over the 8-bit data memory port.
// Memory outputs are decoded from registered state and pointers only.
module mem_copy_dma (
  input  logic       CLK,
  input  logic       reset,
  input  logic       start,
  input  logic       fill,
  input  logic       abort,
  input  logic [7:0] src,
  input  logic [7:0] dst,
  input  logic [7:0] len,
  input  logic [7:0] fill_val,
  output logic [7:0] MemAddr,
  output logic       MemRead,
  output logic       MemWrite,
  output logic [7:0] MemDataOut,
  input  logic [7:0] MemDataIn,
  output logic       busy,
  output logic       done,
  output logic [7:0] count
);
  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;
  state_t state_q, state_d;
  logic [7:0] rp_q, rp_d, wp_q, wp_d, hold_q, hold_d, count_q, count_d;
  logic [7:0] len_q, len_d, fv_q, fv_d, diff, cnt_inc;
  logic fill_q, fill_d, back_q, back_d, go_back;
  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q <= IDLE;
      rp_q    <= 8'd0;
      wp_q    <= 8'd0;
      hold_q  <= 8'd0;
      count_q <= 8'd0;
      len_q   <= 8'd0;
      fv_q    <= 8'd0;
      fill_q  <= 1'b0;
      back_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rp_q    <= rp_d;
      wp_q    <= wp_d;
      hold_q  <= hold_d;
      count_q <= count_d;
      len_q   <= len_d;
      fv_q    <= fv_d;
      fill_q  <= fill_d;
      back_q  <= back_d;
    end
  end
  always_comb begin
    state_d = state_q;
    rp_d    = rp_q;
    wp_d    = wp_q;
    hold_d  = hold_q;
    count_d = count_q;
    len_d   = len_q;
    fv_d    = fv_q;
    fill_d  = fill_q;
    back_d  = back_q;
    diff    = dst - src;
    // Destination lands inside the source window ahead of it: copy from the top down.
    go_back = !fill && (dst != src) && (diff < len);
    cnt_inc = count_q + 8'd1;
    case (state_q)
      IDLE: if (start) begin
        fill_d  = fill;
        len_d   = len;
        fv_d    = fill_val;
        count_d = 8'd0;
        back_d  = go_back;
        rp_d    = go_back ? src + len - 8'd1 : src;
        wp_d    = go_back ? dst + len - 8'd1 : dst;
        state_d = (len == 8'd0) ? DONE : fill ? WR : RD;
      end
      RD: begin
        hold_d  = abort ? hold_q : MemDataIn;
        state_d = abort ? DONE : WR;
      end
      WR: begin
        count_d = cnt_inc;
        rp_d    = back_q ? rp_q - 8'd1 : rp_q + 8'd1;
        wp_d    = back_q ? wp_q - 8'd1 : wp_q + 8'd1;
        state_d = (abort || cnt_inc == len_q) ? DONE : fill_q ? WR : RD;
      end
      default: state_d = IDLE;
    endcase
  end
  assign MemRead    = (state_q == RD);
  assign MemWrite   = (state_q == WR);
  assign MemAddr    = MemRead ? rp_q : MemWrite ? wp_q : 8'd0;
  assign MemDataOut = MemWrite ? (fill_q ? fv_q : hold_q) : 8'd0;
  assign busy       = (state_q != IDLE);
  assign done       = (state_q == DONE);
  assign count      = count_q;
endmodule

// File: tb/tb_mem_copy_dma.sv
// tb_mem_copy_dma: directed and random transfers checked against a memmove/memset model of the memory.
module tb_mem_copy_dma;
  logic CLK = 1'b0, reset = 1'b1, start = 1'b0, fill = 1'b0, abort = 1'b0, ld = 1'b0;
  logic [7:0] src = 8'd0, dst = 8'd0, len = 8'd0, fill_val = 8'd0;
  logic [7:0] MemAddr, MemDataOut, MemDataIn, count;
  logic MemRead, MemWrite, busy, done;
  logic [7:0] mem[256], ldm[256], pre[256], expm[256], wlog[4096];
  int wr_n = 0, rd_n = 0, checks = 0, passed = 0;

  mem_copy_dma dut (
    .CLK(CLK), .reset(reset), .start(start), .fill(fill), .abort(abort),
    .src(src), .dst(dst), .len(len), .fill_val(fill_val),
    .MemAddr(MemAddr), .MemRead(MemRead), .MemWrite(MemWrite),
    .MemDataOut(MemDataOut), .MemDataIn(MemDataIn),
    .busy(busy), .done(done), .count(count)
  );

  always #5 CLK = ~CLK;
  assign MemDataIn = mem[MemAddr];

  always @(posedge CLK) begin
    if (ld) begin
      foreach (mem[i]) mem[i] <= ldm[i];
    end else if (MemWrite) begin
      mem[MemAddr] <= MemDataOut;
      wlog[wr_n % 4096] <= MemAddr;
      wr_n <= wr_n + 1;
    end
    if (MemRead) rd_n <= rd_n + 1;
  end

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic load_rand();
    foreach (ldm[i]) ldm[i] = 8'($urandom);
    @(negedge CLK); ld = 1'b1;
    @(negedge CLK); ld = 1'b0;
  endtask

  // Expected memory: fill writes v to n bytes at d; copy has memmove semantics from the pre-image.
  task automatic check_mem(input string tag, input logic f, input logic [7:0] s, d, v, input int n);
    logic [7:0] a;
    int bad;
    expm = pre;
    for (int i = 0; i < n; i++) begin
      a = d + 8'(i);
      expm[a] = f ? v : pre[8'(s + 8'(i))];
    end
    bad = 0;
    foreach (mem[i]) if (mem[i] !== expm[i]) bad++;
    check(tag, bad, 0);
  endtask

  task automatic run(input string tag, input logic f, input logic [7:0] s, d, l, v, output int w0);
    int cyc, r0;
    @(negedge CLK);
    fill = f; src = s; dst = d; len = l; fill_val = v; start = 1'b1;
    pre = mem; w0 = wr_n; r0 = rd_n;
    @(posedge CLK); #1 start = 1'b0;
    cyc = 0;
    do begin @(negedge CLK); cyc++; end while (!done && cyc < 600);
    check({tag, "_done_cycle"}, cyc, (l == 0) ? 1 : f ? int'(l) + 1 : 2 * int'(l) + 1);
    check({tag, "_count"}, int'(count), int'(l));
    check({tag, "_writes"}, wr_n - w0, int'(l));
    check({tag, "_reads"}, rd_n - r0, f ? 0 : int'(l));
    check_mem({tag, "_mem"}, f, s, d, v, int'(l));
    @(negedge CLK);
    check({tag, "_idle"}, int'({busy, done, MemRead, MemWrite}), 0);
  endtask

  initial begin
    int w0, k;
    logic [7:0] s, d;
    load_rand();
    @(negedge CLK);
    check("reset_outs", int'({MemAddr, MemRead, MemWrite, MemDataOut, busy, done, count}), 0);
    reset = 1'b0;

    // Forward copy
    foreach (ldm[i]) ldm[i] = mem[i];
    for (int i = 0; i < 4; i++) ldm[8'h10 + i] = 8'(i + 1);
    @(negedge CLK); ld = 1'b1; @(negedge CLK); ld = 1'b0;
    run("fwd", 1'b0, 8'h10, 8'h40, 8'd4, 8'd0, w0);
    check("fwd_last_byte", int'(mem[8'h43]), 4);

    // Overlapping copy must run backward
    foreach (ldm[i]) ldm[i] = mem[i];
    for (int i = 0; i < 5; i++) ldm[8'h20 + i] = 8'(10 + i);
    @(negedge CLK); ld = 1'b1; @(negedge CLK); ld = 1'b0;
    run("ovl", 1'b0, 8'h20, 8'h22, 8'd5, 8'd0, w0);
    check("ovl_first_wa", int'(wlog[w0 % 4096]), 'h26);
    check("ovl_top_byte", int'(mem[8'h26]), 14);

    run("wrapfill", 1'b1, 8'h00, 8'hFE, 8'd4, 8'hA5, w0);
    run("zero", 1'b0, 8'h33, 8'h44, 8'd0, 8'd0, w0);

    // Abort at the edge ending the 3rd WR; a stray start while busy is ignored
    @(negedge CLK);
    fill = 1'b0; src = 8'h50; dst = 8'h80; len = 8'd8; start = 1'b1;
    pre = mem; w0 = wr_n;
    @(posedge CLK); #1 start = 1'b0;
    for (k = 1; k <= 6; k++) begin
      @(negedge CLK);
      if (k == 3) begin start = 1'b1; fill = 1'b1; len = 8'd0; end
      if (k == 4) start = 1'b0;
    end
    check("abort_in_wr", int'(MemWrite), 1);
    abort = 1'b1;
    @(negedge CLK); abort = 1'b0;
    check("abort_done", int'(done), 1);
    check("abort_count", int'(count), 3);
    check("abort_writes", wr_n - w0, 3);
    check_mem("abort_mem", 1'b0, 8'h50, 8'h80, 8'd0, 3);
    @(negedge CLK);
    check("abort_idle", int'({busy, done, MemRead, MemWrite}), 0);
    @(negedge CLK);
    check("abort_no_restart", int'(busy), 0);

    // Reset after 4 fill writes
    @(negedge CLK);
    fill = 1'b1; dst = 8'h30; len = 8'd10; fill_val = 8'h5A; start = 1'b1;
    pre = mem; w0 = wr_n;
    @(posedge CLK); #1 start = 1'b0;
    repeat (4) @(negedge CLK);
    reset = 1'b1;
    @(negedge CLK);
    check("rst_outs", int'({MemAddr, MemRead, MemWrite, MemDataOut, busy, done, count}), 0);
    check("rst_writes", wr_n - w0, 4);
    check_mem("rst_mem", 1'b1, 8'h00, 8'h30, 8'h5A, 4);
    reset = 1'b0;
    run("after_rst", 1'b0, 8'h30, 8'hC0, 8'd6, 8'd0, w0);

    // Random transfers, overlap biased, len kept <= 100 so memmove semantics hold
    for (int t = 0; t < 20; t++) begin
      load_rand();
      s = 8'($urandom);
      d = ($urandom_range(0, 1) == 1) ? 8'(s + 8'($urandom_range(0, 8))) : 8'($urandom);
      if ($urandom_range(0, 1) == 1) d = 8'(s - 8'($urandom_range(0, 8)));
      run("rnd", 1'($urandom_range(0, 1)), s, d, 8'($urandom_range(0, 100)), 8'($urandom), w0);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
